// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words LSB-first into ccff_head
// and optionally re-shifts to compare ccff_tail against the expected bits.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int BC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int WI_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              mode;
  logic              mode_n;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_n;
  logic [WI_W-1:0]   word_idx;
  logic [WI_W-1:0]   word_idx_n;
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   bit_cnt_n;
  logic              mis_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              last_bit;
  logic              last_word;
  logic              miss;

  assign s_ready   = (state == FETCH);
  assign last_bit  = (bit_cnt == BC_W'(CHAIN_LEN - 1));
  assign last_word = (word_idx == WI_W'(WORD_W - 1));
  // ccff_head is the registered copy of sreg[0], so it pairs with this cycle's tail
  assign miss      = mode & (ccff_head != ccff_tail);

  always_comb begin
    state_n    = state;
    mode_n     = mode;
    sreg_n     = sreg;
    word_idx_n = word_idx;
    bit_cnt_n  = bit_cnt;
    mis_n      = mismatch;
    cnt_n      = mismatch_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_n    = verify;
          bit_cnt_n = '0;
          mis_n     = 1'b0;
          cnt_n     = '0;
          state_n   = FETCH;
        end
      end
      FETCH: begin
        if (s_valid) begin
          sreg_n     = s_data;
          word_idx_n = '0;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        sreg_n     = sreg >> 1;
        word_idx_n = word_idx + 1'b1;
        bit_cnt_n  = last_bit ? '0 : bit_cnt + 1'b1;
        if (miss) begin
          mis_n = 1'b1;
          if (~&mismatch_cnt) begin
            cnt_n = mismatch_cnt + 1'b1;
          end
        end
        if (last_bit) begin
          state_n = DONE;
        end else if (last_word) begin
          state_n = FETCH;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      mode          <= 1'b0;
      sreg          <= '0;
      word_idx      <= '0;
      bit_cnt       <= '0;
      mismatch      <= 1'b0;
      mismatch_cnt  <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      mode          <= mode_n;
      sreg          <= sreg_n;
      word_idx      <= word_idx_n;
      bit_cnt       <= bit_cnt_n;
      mismatch      <= mis_n;
      mismatch_cnt  <= cnt_n;
      ccff_head     <= (state_n == SHIFT) & sreg_n[0];
      ccff_shift_en <= (state_n == SHIFT);
      busy          <= (state_n != IDLE);
      done          <= (state_n == DONE);
    end
  end

endmodule
